// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - fetch-stage bus widths, bus layouts and PC helper
`ifndef MYCPU_H
`define MYCPU_H
`define FS_TO_DS_BUS_WD 64
`define BR_BUS_WD 33
`endif

package if_stage_pkg;

    // Decode-stage redirect: {br_taken, br_target}
    typedef struct packed {
        logic        taken;
        logic [31:0] target;
    } br_bus_t;

    // Fetch-to-decode payload: {inst, pc}
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    function automatic logic [31:0] seq_pc(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage.sv
// rtl/if_stage.sv - fetch stage: owns the PC, issues inst_sram reads, feeds decode
// Define IF_PERF_CNT_EN to add the fs_perf_fetch_cnt / fs_perf_cancel_cnt outputs.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        ds_allowin,
    input  logic [`BR_BUS_WD-1:0]       br_bus,
    output logic                        fs_to_ds_valid,
    output logic [`FS_TO_DS_BUS_WD-1:0] fs_to_ds_bus,
    output logic                        inst_sram_req,
    output logic [31:0]                 inst_sram_addr,
    input  logic                        inst_sram_addr_ok,
    input  logic                        inst_sram_data_ok,
    input  logic [31:0]                 inst_sram_rdata
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]                 fs_perf_fetch_cnt,
    output logic [31:0]                 fs_perf_cancel_cnt
`endif
);

    br_bus_t     br;
    fs_to_ds_t   out_bus;
    logic        reset_state;
    logic        fs_valid;
    logic        buf_valid;
    logic [31:0] buf_inst;
    logic [31:0] fs_pc;
    logic        br_buf_valid;
    logic [31:0] br_buf_target;
    logic        stale;
    logic        discard;
    logic        req_from_br;
    logic        br_redirect;
    logic        accept;
    logic        data_in_wait;
    logic        fs_ready_go;
    logic        fs_allowin;
    logic        transfer;
    logic        raise;
    logic [31:0] nextpc;

    assign br           = br_bus;
    assign br_redirect  = br.taken && ds_allowin;
    assign accept       = inst_sram_req && inst_sram_addr_ok;
    assign data_in_wait = fs_valid && !buf_valid && !discard && inst_sram_data_ok;
    assign fs_ready_go  = buf_valid || data_in_wait;
    assign fs_allowin   = !fs_valid || (fs_ready_go && ds_allowin);
    assign fs_to_ds_valid = fs_valid && fs_ready_go;
    assign transfer     = fs_to_ds_valid && ds_allowin;
    // The redirect cycle never raises: the target must first land in br_buf.
    assign raise        = !inst_sram_req && fs_allowin && !discard && !reset_state && !br_redirect;
    assign nextpc       = br_buf_valid ? br_buf_target : seq_pc(fs_pc);

    assign out_bus.inst = !fs_to_ds_valid ? 32'h0 : (buf_valid ? buf_inst : inst_sram_rdata);
    assign out_bus.pc   = fs_pc;
    assign fs_to_ds_bus = out_bus;

    // Request channel: raise when IF can take a new word, then hold req/addr until accepted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            reset_state    <= 1'b1;
            inst_sram_req  <= 1'b0;
            inst_sram_addr <= RESET_PC;
            req_from_br    <= 1'b0;
        end else begin
            reset_state <= 1'b0;
            if (accept) begin
                inst_sram_req <= 1'b0;
            end else if (raise) begin
                inst_sram_req  <= 1'b1;
                inst_sram_addr <= nextpc;
                req_from_br    <= br_buf_valid;
            end
            // A newer target now sits in br_buf; the held request must not retire it.
            if (br_redirect) begin
                req_from_br <= 1'b0;
            end
        end
    end

    // Fetch state: PC, IF valid, 1-entry inst buffer, branch buffer and cancel flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_pc         <= RESET_PC - 32'd4;
            fs_valid      <= 1'b0;
            buf_valid     <= 1'b0;
            buf_inst      <= 32'h0;
            br_buf_valid  <= 1'b0;
            br_buf_target <= 32'h0;
            stale         <= 1'b0;
            discard       <= 1'b0;
        end else begin
            if (accept) begin
                fs_pc <= inst_sram_addr;
                if (req_from_br) begin
                    br_buf_valid <= 1'b0;
                end
                if (stale) begin
                    discard <= 1'b1;
                    stale   <= 1'b0;
                end else begin
                    fs_valid <= 1'b1;
                end
            end else if (transfer) begin
                fs_valid <= 1'b0;
            end

            if (discard && inst_sram_data_ok) begin
                discard <= 1'b0;
            end

            if (data_in_wait && !ds_allowin) begin
                buf_valid <= 1'b1;
                buf_inst  <= inst_sram_rdata;
            end else if (transfer) begin
                buf_valid <= 1'b0;
            end

            // Redirect wins over every update above
            if (br_redirect) begin
                br_buf_valid  <= 1'b1;
                br_buf_target <= br.target;
                fs_valid      <= 1'b0;
                buf_valid     <= 1'b0;
                if (accept || (fs_valid && !buf_valid && !inst_sram_data_ok)) begin
                    discard <= 1'b1;
                end
                if (inst_sram_req && !accept) begin
                    stale <= 1'b1;
                end
            end
        end
    end

`ifdef IF_PERF_CNT_EN
    logic cancel_ev;
    assign cancel_ev = (discard && inst_sram_data_ok) ||
                       (br_redirect && (buf_valid || data_in_wait));

    // Performance counters: delivered instructions and cancelled fetches
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fs_perf_fetch_cnt  <= 32'h0;
            fs_perf_cancel_cnt <= 32'h0;
        end else begin
            if (transfer) begin
                fs_perf_fetch_cnt <= fs_perf_fetch_cnt + 32'd1;
            end
            if (cancel_ev) begin
                fs_perf_cancel_cnt <= fs_perf_cancel_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
